// File: rtl/pipeline_fork_fifo_if.sv
// Handshake bundle for pipeline_fork_fifo: one producer-side stream and N consumer-side streams.
// Latency/backpressure are properties of the fork itself; this only groups the wires.
interface pipeline_fork_fifo_if #(
    parameter int N     = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH + 1);

    logic                   i_valid;
    logic                   i_ready;
    logic [DW-1:0]          i_data;
    logic [N-1:0]           i_mask;
    logic [N-1:0]           o_valid;
    logic [N-1:0]           o_ready;
    logic [N-1:0][DW-1:0]   o_data;
    logic [N-1:0][LW-1:0]   o_level;

    modport master (
        output i_valid, i_data, i_mask, o_ready,
        input  i_ready, o_valid, o_data, o_level
    );

    modport slave (
        input  i_valid, i_data, i_mask, o_ready,
        output i_ready, o_valid, o_data, o_level
    );
endinterface

// File: rtl/pipeline_fork_fifo.sv
// Multicast fork: one valid/ready stream into N per-output DEPTH-entry FIFOs (PIPELINE_FORK_BYPASS_EN adds cut-through).
// Latency: 1 cycle input accept to o_valid; 0 cycles on an empty output when bypass is built in.
// Backpressure: i_ready drops while any masked FIFO is full; it depends only on i_mask and registered levels.
module pipeline_fork_fifo #(
    parameter int N     = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_fork_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW-1:0]  wr_ptr_q [N];
    logic [AW-1:0]  wr_ptr_d [N];
    logic [AW-1:0]  rd_ptr_q [N];
    logic [AW-1:0]  rd_ptr_d [N];
    logic [LW-1:0]  level_q  [N];
    logic [LW-1:0]  level_d  [N];
    logic [DW-1:0]  mem_q    [N][DEPTH];
    logic [DW-1:0]  mem_d    [N][DEPTH];

    logic [N-1:0]           full;
    logic [N-1:0]           empty;
    logic [N-1:0]           push;
    logic [N-1:0]           store;
    logic [N-1:0]           pop;
    logic [N-1:0]           o_valid;
    logic [N-1:0][DW-1:0]   o_data;
    logic [N-1:0][LW-1:0]   o_level;
    logic                   i_ready;
    logic                   accept;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < N; i++) begin
            full[i]  = (level_q[i] == LW'(DEPTH));
            empty[i] = (level_q[i] == '0);
        end
    end

    // Whole-beat acceptance: a single full destination holds off every destination.
    assign i_ready = &(~bus.i_mask | ~full);
    assign accept  = bus.i_valid & i_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        push     = '0;
        store    = '0;
        pop      = '0;
        o_valid  = '0;
        o_data   = '0;
        o_level  = '0;
        for (int i = 0; i < N; i++) begin
            push[i] = accept & bus.i_mask[i];
`ifdef PIPELINE_FORK_BYPASS_EN
            o_valid[i] = !empty[i] || push[i];
            if (!empty[i])
                o_data[i] = mem_q[i][rd_ptr_q[i]];
            else if (push[i])
                o_data[i] = bus.i_data;
            // A cut-through beat taken by the consumer never occupies the FIFO.
            store[i] = push[i] && !(empty[i] && bus.o_ready[i]);
`else
            o_valid[i] = !empty[i];
            if (!empty[i])
                o_data[i] = mem_q[i][rd_ptr_q[i]];
            store[i] = push[i];
`endif
            pop[i] = !empty[i] && bus.o_ready[i];
            if (store[i]) begin
                mem_d[i][wr_ptr_q[i]] = bus.i_data;
                wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
            end
            if (pop[i])
                rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            level_d[i] = level_q[i] + LW'(store[i]) - LW'(pop[i]);
            o_level[i] = level_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                level_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; levels gate everything read from it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.i_ready = i_ready;
    assign bus.o_valid = o_valid;
    assign bus.o_data  = o_data;
    assign bus.o_level = o_level;
endmodule

// File: tb/tb_pipeline_fork_fifo.sv
// Directed bench for pipeline_fork_fifo with N=2, DW=8, DEPTH=2.
module tb_pipeline_fork_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_fork_fifo_if #(.N(2), .DW(8), .DEPTH(2)) bus ();

    pipeline_fork_fifo #(.N(2), .DW(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.i_valid = 1'b0; bus.i_data = 8'h00; bus.i_mask = 2'b11; bus.o_ready = 2'b00;
        step(); step();
        rst = 1'b1; #1;
        checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", bus.o_valid); end
        checks++; if (bus.o_level[0] !== 2'd0 || bus.o_level[1] !== 2'd0) begin errors++; $display("FAIL rst_level got %0d/%0d want 0/0", bus.o_level[0], bus.o_level[1]); end
        checks++; if (bus.o_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h want 0000", bus.o_data); end
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.i_ready); end
    endtask

    task automatic test_multicast();
        bus.i_valid = 1'b1; bus.i_data = 8'hA5; bus.i_mask = 2'b11; bus.o_ready = 2'b00; #1;
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL mc_ready got %b want 1", bus.i_ready); end
        step();
        bus.i_valid = 1'b0; bus.o_ready = 2'b11; #1;
        checks++; if (bus.o_valid !== 2'b11) begin errors++; $display("FAIL mc_valid got %b want 11", bus.o_valid); end
        checks++; if (bus.o_data[0] !== 8'hA5 || bus.o_data[1] !== 8'hA5) begin errors++; $display("FAIL mc_data got %h/%h want a5/a5", bus.o_data[0], bus.o_data[1]); end
        step();
        checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL mc_drain_valid got %b want 00", bus.o_valid); end
        checks++; if (bus.o_level[0] !== 2'd0 || bus.o_level[1] !== 2'd0) begin errors++; $display("FAIL mc_drain_level got %0d/%0d want 0/0", bus.o_level[0], bus.o_level[1]); end
    endtask

    task automatic test_slow_consumer();
        bus.o_ready = 2'b01; bus.i_valid = 1'b1; bus.i_data = 8'h01; bus.i_mask = 2'b11;
        step();
        bus.i_data = 8'h02; #1;
        checks++; if (bus.o_data[0] !== 8'h01) begin errors++; $display("FAIL slow_out0_first got %h want 01", bus.o_data[0]); end
        step();
        #1;
        checks++; if (bus.o_level[1] !== 2'd2) begin errors++; $display("FAIL slow_level1 got %0d want 2", bus.o_level[1]); end
        checks++; if (bus.o_data[0] !== 8'h02) begin errors++; $display("FAIL slow_out0_second got %h want 02", bus.o_data[0]); end
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL slow_ready_m11 got %b want 0", bus.i_ready); end
        bus.i_mask = 2'b10; #1;
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL slow_ready_m10 got %b want 0", bus.i_ready); end
        bus.i_mask = 2'b01; bus.i_data = 8'h03; #1;
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL slow_ready_m01 got %b want 1", bus.i_ready); end
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_data[0] !== 8'h03) begin errors++; $display("FAIL slow_out0_third got %h want 03", bus.o_data[0]); end
        checks++; if (bus.o_data[1] !== 8'h01 || bus.o_level[1] !== 2'd2) begin errors++; $display("FAIL slow_out1_held got %h lvl %0d want 01 lvl 2", bus.o_data[1], bus.o_level[1]); end
        step();
        checks++; if (bus.o_valid !== 2'b10) begin errors++; $display("FAIL slow_valid_after got %b want 10", bus.o_valid); end
    endtask

    task automatic test_mask_zero();
        bus.i_valid = 1'b1; bus.i_mask = 2'b00; bus.i_data = 8'h77; #1;
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", bus.i_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.o_valid !== 2'b10 || bus.o_level[0] !== 2'd0 || bus.o_level[1] !== 2'd2 || bus.o_data[1] !== 8'h01) begin
                errors++;
                $display("FAIL drop_cycle%0d got v=%b lvl=%0d/%0d d1=%h want v=10 lvl=0/2 d1=01", k, bus.o_valid, bus.o_level[0], bus.o_level[1], bus.o_data[1]);
            end
        end
    endtask

    task automatic test_full_pop();
        bus.i_valid = 1'b1; bus.i_mask = 2'b10; bus.i_data = 8'h04; bus.o_ready = 2'b10; #1;
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready_same got %b want 0", bus.i_ready); end
        step();
        bus.o_ready = 2'b00; #1;
        checks++; if (bus.o_level[1] !== 2'd1 || bus.o_data[1] !== 8'h02) begin errors++; $display("FAIL fullpop_after got lvl %0d d %h want 1 02", bus.o_level[1], bus.o_data[1]); end
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_next got %b want 1", bus.i_ready); end
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_level[1] !== 2'd2 || bus.o_data[1] !== 8'h02) begin errors++; $display("FAIL fullpop_accept got lvl %0d d %h want 2 02", bus.o_level[1], bus.o_data[1]); end
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready_full got %b want 0", bus.i_ready); end
        bus.i_valid = 1'b1; bus.i_mask = 2'b01; bus.i_data = 8'h05;
        step();
        bus.i_data = 8'h06;
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_level[0] !== 2'd2 || bus.o_level[1] !== 2'd2 || bus.o_data[0] !== 8'h05) begin errors++; $display("FAIL fill_both got lvl %0d/%0d d0 %h want 2/2 05", bus.o_level[0], bus.o_level[1], bus.o_data[0]); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b0;
        step();
        rst = 1'b1; #1;
        checks++; if (bus.o_valid !== 2'b00 || bus.o_data !== 16'h0000) begin errors++; $display("FAIL midrst_out got v=%b d=%h want 00 0000", bus.o_valid, bus.o_data); end
        checks++; if (bus.o_level[0] !== 2'd0 || bus.o_level[1] !== 2'd0) begin errors++; $display("FAIL midrst_level got %0d/%0d want 0/0", bus.o_level[0], bus.o_level[1]); end
        bus.i_mask = 2'b11; #1;
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.i_ready); end
        bus.i_valid = 1'b1; bus.i_data = 8'h11;
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_data[0] !== 8'h11 || bus.o_data[1] !== 8'h11 || bus.o_level[0] !== 2'd1) begin errors++; $display("FAIL midrst_fresh got %h/%h lvl %0d want 11/11 lvl 1", bus.o_data[0], bus.o_data[1], bus.o_level[0]); end
        bus.o_ready = 2'b11;
        step();
        checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL midrst_stale got v=%b want 00", bus.o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        bus.o_ready = 2'b11; bus.i_mask = 2'b11; bus.i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = 8'h20 + 8'(k);
            bus.i_data = exp;
            step();
            checks++;
            if (bus.o_data[0] !== exp || bus.o_data[1] !== exp || bus.o_level[0] !== 2'd1 || bus.o_level[1] !== 2'd1) begin
                errors++;
                $display("FAIL b2b_beat%0d got %h/%h lvl %0d/%0d want %h/%h lvl 1/1", k, bus.o_data[0], bus.o_data[1], bus.o_level[0], bus.o_level[1], exp, exp);
            end
        end
        bus.i_valid = 1'b0;
        step();
        checks++; if (bus.o_valid !== 2'b00 || bus.o_level[0] !== 2'd0) begin errors++; $display("FAIL b2b_drain got v=%b lvl %0d want 00 0", bus.o_valid, bus.o_level[0]); end
    endtask

    task automatic test_latency();
        bus.o_ready = 2'b11; bus.i_mask = 2'b11; bus.i_data = 8'h3C; bus.i_valid = 1'b1; #1;
`ifdef PIPELINE_FORK_BYPASS_EN
        checks++; if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 8'h3C || bus.o_data[1] !== 8'h3C) begin errors++; $display("FAIL byp_same got v=%b d=%h/%h want 11 3c/3c", bus.o_valid, bus.o_data[0], bus.o_data[1]); end
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_level[0] !== 2'd0 || bus.o_level[1] !== 2'd0 || bus.o_valid !== 2'b00) begin errors++; $display("FAIL byp_level got lvl %0d/%0d v=%b want 0/0 00", bus.o_level[0], bus.o_level[1], bus.o_valid); end
`else
        checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL lat_same got v=%b want 00", bus.o_valid); end
        step();
        bus.i_valid = 1'b0; #1;
        checks++; if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 8'h3C || bus.o_data[1] !== 8'h3C) begin errors++; $display("FAIL lat_next got v=%b d=%h/%h want 11 3c/3c", bus.o_valid, bus.o_data[0], bus.o_data[1]); end
        step();
        checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL lat_drain got v=%b want 00", bus.o_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_multicast();
        test_slow_consumer();
        test_mask_zero();
        test_full_pop();
        test_mid_reset();
        test_back_to_back();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
